// File: rtl/tt_vpu_pkg.sv
// Shared VPU definitions used by the load queue and its storage.
//   LQ_DEPTH / LQ_PTR_W / LQ_CNT_W : load queue geometry
//   LQ_DATA_W / LQ_MASK_W          : OVI load beat payload widths
//   OVI_SEQ_W                      : OVI seq_id width
//   lq_entry_t                     : one buffered load beat
package tt_vpu_pkg;

    localparam int unsigned LQ_DEPTH  = 16;
    localparam int unsigned LQ_PTR_W  = $clog2(LQ_DEPTH);
    localparam int unsigned LQ_CNT_W  = LQ_PTR_W + 1;
    localparam int unsigned LQ_DATA_W = 512;
    localparam int unsigned LQ_MASK_W = LQ_DATA_W / 8;
    localparam int unsigned OVI_SEQ_W = 34;

    typedef struct packed {
        logic [LQ_DATA_W-1:0] data;
        logic [LQ_MASK_W-1:0] mask;
        logic [OVI_SEQ_W-1:0] seq_id;
    } lq_entry_t;

endpackage : tt_vpu_pkg

// File: rtl/tt_lq_storage.sv
// Load queue entry storage: DEPTH x lq_entry_t register array.
// Kept behind a plain write-port / async-read-port boundary so it can later
// be replaced by an SRAM macro without touching the queue control.
//   i_clk     : clock
//   i_we      : write enable
//   i_waddr   : write slot
//   i_wentry  : entry to write
//   i_raddr   : read slot
//   o_rentry  : entry at i_raddr (combinational)
module tt_lq_storage
    import tt_vpu_pkg::*;
#(
    parameter int unsigned DEPTH  = LQ_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  lq_entry_t         i_wentry,
    input  logic [ADDR_W-1:0] i_raddr,
    output lq_entry_t         o_rentry
);

    // Payload storage is intentionally not reset; validity lives in the control.
    lq_entry_t mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wentry;
        end
    end

    assign o_rentry = mem_q[i_raddr];

endmodule : tt_lq_storage

// File: rtl/tt_vpu_load_queue.sv
// VPU load queue: buffers OVI load beats and drains them in order to the VRF
// writeback port, returning one OVI load credit per drained beat.
//   i_clk, i_reset_n          : clock, synchronous active-low reset
//   i_load_valid/data/seq_id/mask : incoming OVI load beat (no backpressure)
//   o_wb_valid/data/seq_id/mask   : head entry offered to writeback
//   i_wb_rdy                  : writeback accepts the head entry
//   o_load_credit             : one-cycle pulse, one per drained beat
//   o_lq_empty / o_lq_count   : occupancy status for the memop FSM
//   o_overflow                : sticky, a beat arrived while full without a pop
module tt_vpu_load_queue
    import tt_vpu_pkg::*;
#(
    parameter int unsigned DEPTH  = LQ_DEPTH,
    parameter int unsigned DATA_W = LQ_DATA_W,
    parameter int unsigned MASK_W = DATA_W / 8,
    parameter int unsigned SEQ_W  = OVI_SEQ_W
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_load_valid,
    input  logic [DATA_W-1:0]        i_load_data,
    input  logic [SEQ_W-1:0]         i_load_seq_id,
    input  logic [MASK_W-1:0]        i_load_mask,
    output logic                     o_wb_valid,
    output logic [DATA_W-1:0]        o_wb_data,
    output logic [SEQ_W-1:0]         o_wb_seq_id,
    output logic [MASK_W-1:0]        o_wb_mask,
    input  logic                     i_wb_rdy,
    output logic                     o_load_credit,
    output logic                     o_lq_empty,
    output logic [$clog2(DEPTH):0]   o_lq_count,
    output logic                     o_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             credit_q, credit_d;
    logic             overflow_q, overflow_d;

    logic      full;
    logic      not_empty;
    logic      pop;
    logic      push;
    lq_entry_t wentry;
    lq_entry_t rentry;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign not_empty = (count_q != '0);
    assign pop       = not_empty && i_wb_rdy;
    // A pop in the same cycle frees the slot, so a push at full is still legal then.
    assign push      = i_load_valid && (!full || pop);

    // Pack the incoming beat into a storage entry.
    always_comb begin
        wentry        = '0;
        wentry.data   = LQ_DATA_W'(i_load_data);
        wentry.mask   = LQ_MASK_W'(i_load_mask);
        wentry.seq_id = OVI_SEQ_W'(i_load_seq_id);
    end

    tt_lq_storage #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_storage (
        .i_clk    (i_clk),
        .i_we     (push),
        .i_waddr  (wr_ptr_q),
        .i_wentry (wentry),
        .i_raddr  (rd_ptr_q),
        .o_rentry (rentry)
    );

    // Next-state for pointers, occupancy, credit and overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        credit_d   = pop;
        overflow_d = overflow_q;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Core overran its credits: beat is dropped, flag stays until reset.
        if (i_load_valid && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // State registers; reset also cancels a pending credit pulse.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Head and status are decoded straight from state; no push-to-head bypass.
    assign o_wb_valid    = not_empty;
    assign o_wb_data     = DATA_W'(rentry.data);
    assign o_wb_mask     = MASK_W'(rentry.mask);
    assign o_wb_seq_id   = SEQ_W'(rentry.seq_id);
    assign o_lq_empty    = !not_empty;
    assign o_lq_count    = count_q;
    assign o_load_credit = credit_q;
    assign o_overflow    = overflow_q;

endmodule : tt_vpu_load_queue

// File: tb/tb_tt_vpu_load_queue.sv
// Self-checking bench for tt_vpu_load_queue: directed scenarios plus a
// credit-bounded random phase checked against a queue model.
module tb_tt_vpu_load_queue;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned MASK_W = 64;
    localparam int unsigned SEQ_W  = 34;
    localparam int unsigned CNT_W  = 5;

    logic              clk;
    logic              reset_n;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic [SEQ_W-1:0]  load_seq_id;
    logic [MASK_W-1:0] load_mask;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic [SEQ_W-1:0]  wb_seq_id;
    logic [MASK_W-1:0] wb_mask;
    logic              wb_rdy;
    logic              load_credit;
    logic              lq_empty;
    logic [CNT_W-1:0]  lq_count;
    logic              overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Random-phase model
    logic [SEQ_W-1:0]  seq_q  [$];
    logic [MASK_W-1:0] mask_q [$];
    int                credits;
    int                n_pops;
    int                n_pulses;
    logic              exp_credit;
    logic [SEQ_W-1:0]  next_seq;

    tt_vpu_load_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .MASK_W (MASK_W),
        .SEQ_W  (SEQ_W)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_load_valid  (load_valid),
        .i_load_data   (load_data),
        .i_load_seq_id (load_seq_id),
        .i_load_mask   (load_mask),
        .o_wb_valid    (wb_valid),
        .o_wb_data     (wb_data),
        .o_wb_seq_id   (wb_seq_id),
        .o_wb_mask     (wb_mask),
        .i_wb_rdy      (wb_rdy),
        .o_load_credit (load_credit),
        .o_lq_empty    (lq_empty),
        .o_lq_count    (lq_count),
        .o_overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk_data(input logic [SEQ_W-1:0] s);
        logic [31:0] w;
        w = 32'(s) * 32'd2654435761 + 32'h1357_9bdf;
        return {16{w}};
    endfunction

    // Advance one cycle: inputs are driven and outputs sampled at negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_beat(input logic v, input logic [SEQ_W-1:0] s, input logic [MASK_W-1:0] m);
        load_valid  = v;
        load_seq_id = s;
        load_mask   = m;
        load_data   = mk_data(s);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive_beat(1'b0, '0, '0);
        wb_rdy  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            drive_beat(1'b1, SEQ_W'(base + i), MASK_W'(64'hF0F0_0000_0000_0000) | MASK_W'(i));
            tick();
        end
        drive_beat(1'b0, '0, '0);
    endtask

    task automatic drain_check(input int n, input int base, input string tag);
        wb_rdy = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_seq"}, DATA_W'(wb_seq_id), DATA_W'(base + i));
            chk({tag, "_data"}, wb_data, mk_data(SEQ_W'(base + i)));
            tick();
            chk({tag, "_credit"}, DATA_W'(load_credit), 1);
        end
        wb_rdy = 1'b0;
        chk({tag, "_empty"}, DATA_W'(lq_empty), 1);
        tick();
        chk({tag, "_credit_end"}, DATA_W'(load_credit), 0);
    endtask

    // One random cycle: check outputs against the model, then pick new inputs.
    task automatic rnd_cycle(input bit en_push);
        bit do_push;
        bit do_pop;
        bit rdy;
        logic [MASK_W-1:0] m;
        chk("rnd_empty", DATA_W'(lq_empty), DATA_W'(seq_q.size() == 0));
        chk("rnd_count", DATA_W'(lq_count), DATA_W'(seq_q.size()));
        chk("rnd_valid", DATA_W'(wb_valid), DATA_W'(seq_q.size() != 0));
        chk("rnd_credit", DATA_W'(load_credit), DATA_W'(exp_credit));
        if (load_credit) begin
            credits++;
            n_pulses++;
        end
        if (seq_q.size() != 0) begin
            chk("rnd_head_seq", DATA_W'(wb_seq_id), DATA_W'(seq_q[0]));
            chk("rnd_head_mask", DATA_W'(wb_mask), DATA_W'(mask_q[0]));
            chk("rnd_head_data", wb_data, mk_data(seq_q[0]));
        end
        do_push = en_push && (credits > 0) && ($urandom_range(0, 99) < 60);
        rdy     = ($urandom_range(0, 99) < 55);
        do_pop  = rdy && (seq_q.size() != 0);
        m       = {$urandom, $urandom};
        drive_beat(do_push, next_seq, m);
        wb_rdy  = rdy;
        if (do_pop) begin
            void'(seq_q.pop_front());
            void'(mask_q.pop_front());
            n_pops++;
        end
        if (do_push) begin
            seq_q.push_back(next_seq);
            mask_q.push_back(m);
            credits--;
            next_seq = next_seq + SEQ_W'(1);
        end
        exp_credit = do_pop;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        wb_rdy  = 1'b0;
        drive_beat(1'b0, '0, '0);
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_empty", DATA_W'(lq_empty), 1);
        chk("rst_count", DATA_W'(lq_count), 0);
        chk("rst_valid", DATA_W'(wb_valid), 0);
        chk("rst_credit", DATA_W'(load_credit), 0);
        chk("rst_overflow", DATA_W'(overflow), 0);

        // Single beat: visible next cycle, credit one cycle after pop
        drive_beat(1'b1, SEQ_W'(5), MASK_W'(64'hFF));
        tick();
        drive_beat(1'b0, '0, '0);
        chk("one_valid", DATA_W'(wb_valid), 1);
        chk("one_seq", DATA_W'(wb_seq_id), 5);
        chk("one_mask", DATA_W'(wb_mask), DATA_W'(64'hFF));
        chk("one_data", wb_data, mk_data(SEQ_W'(5)));
        chk("one_count", DATA_W'(lq_count), 1);
        tick();
        chk("one_hold_valid", DATA_W'(wb_valid), 1);
        chk("one_no_credit", DATA_W'(load_credit), 0);
        wb_rdy = 1'b1;
        tick();
        wb_rdy = 1'b0;
        chk("one_credit", DATA_W'(load_credit), 1);
        chk("one_empty", DATA_W'(lq_empty), 1);
        tick();
        chk("one_credit_once", DATA_W'(load_credit), 0);

        // Ready while empty has no effect
        wb_rdy = 1'b1;
        tick();
        wb_rdy = 1'b0;
        chk("rdy_empty_count", DATA_W'(lq_count), 0);
        tick();
        chk("rdy_empty_credit", DATA_W'(load_credit), 0);

        // Fill to 16, then overflow push is dropped
        do_reset();
        fill(16, 0);
        chk("full_count", DATA_W'(lq_count), 16);
        chk("full_no_ovf", DATA_W'(overflow), 0);
        drive_beat(1'b1, SEQ_W'(99), '1);
        tick();
        drive_beat(1'b0, '0, '0);
        chk("ovf_set", DATA_W'(overflow), 1);
        chk("ovf_count", DATA_W'(lq_count), 16);
        drain_check(16, 0, "ovf_drain");
        chk("ovf_sticky", DATA_W'(overflow), 1);
        do_reset();
        chk("ovf_cleared", DATA_W'(overflow), 0);

        // Full with simultaneous push and pop, then drain across the wrap
        fill(16, 0);
        drive_beat(1'b1, SEQ_W'(16), MASK_W'(64'hABCD));
        wb_rdy = 1'b1;
        tick();
        drive_beat(1'b0, '0, '0);
        wb_rdy = 1'b0;
        chk("pp_count", DATA_W'(lq_count), 16);
        chk("pp_no_ovf", DATA_W'(overflow), 0);
        chk("pp_credit", DATA_W'(load_credit), 1);
        drain_check(16, 1, "wrap_drain");

        // Pop at count 1 with simultaneous push keeps the queue non-empty
        fill(1, 30);
        drive_beat(1'b1, SEQ_W'(31), MASK_W'(64'h1234));
        wb_rdy = 1'b1;
        tick();
        drive_beat(1'b0, '0, '0);
        chk("c1_empty", DATA_W'(lq_empty), 0);
        chk("c1_count", DATA_W'(lq_count), 1);
        chk("c1_seq", DATA_W'(wb_seq_id), 31);
        chk("c1_mask", DATA_W'(wb_mask), DATA_W'(64'h1234));
        tick();
        wb_rdy = 1'b0;
        chk("c1_empty_after", DATA_W'(lq_empty), 1);

        // Reset with 7 held entries and a pop in flight cancels everything
        tick();
        fill(7, 40);
        chk("r7_count", DATA_W'(lq_count), 7);
        wb_rdy  = 1'b1;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        wb_rdy  = 1'b0;
        chk("r7_empty", DATA_W'(lq_empty), 1);
        chk("r7_credit", DATA_W'(load_credit), 0);
        tick();
        chk("r7_credit_next", DATA_W'(load_credit), 0);
        fill(1, 50);
        chk("r7_resume_seq", DATA_W'(wb_seq_id), 50);
        chk("r7_resume_count", DATA_W'(lq_count), 1);

        // Random phase, credit-bounded
        do_reset();
        seq_q.delete();
        mask_q.delete();
        credits    = DEPTH;
        n_pops     = 0;
        n_pulses   = 0;
        exp_credit = 1'b0;
        next_seq   = SEQ_W'(1000);
        for (int c = 0; c < 10000; c++) begin
            rnd_cycle(1'b1);
        end
        for (int c = 0; c < 200; c++) begin
            rnd_cycle(1'b0);
        end
        chk("rnd_pulses_eq_pops", DATA_W'(n_pulses), DATA_W'(n_pops));
        chk("rnd_drained", DATA_W'(seq_q.size()), 0);
        chk("rnd_no_ovf", DATA_W'(overflow), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tt_vpu_load_queue

// File: doc/tt_vpu_load_queue.md
# tt_vpu_load_queue

Buffers OVI load-data beats arriving from the core's memory pipeline and drains them in order into the VPU register-file writeback port. It returns one OVI load credit per drained beat. It exports the `o_lq_empty` status that the memop FSM uses to gate its COMMIT→IDLE transition and `completed_valid`. It sits between the OVI load interface and the VRF writeback arbiter.

## Interface
- `DEPTH`, 16: entries; must be a power of 2, ≥2; equals the load credits the core holds after reset.
- `DATA_W`, 512: load beat width in bits.
- `MASK_W`, 64: byte-enable width (`DATA_W/8`).
- `SEQ_W`, 34: OVI `seq_id` width.

Ports:
- `i_clk`  in  1  clock
- `i_reset_n`  in  1  reset; synchronous, active-low; one clock domain
- `i_load_valid`  in  1  OVI load beat present; no backpressure
- `i_load_data`  in  `DATA_W`  load data
- `i_load_seq_id`  in  `SEQ_W`  beat sequence id
- `i_load_mask`  in  `MASK_W`  byte enables for the beat
- `o_wb_valid`  out  1  head entry valid
- `o_wb_data`  out  `DATA_W`  head data
- `o_wb_seq_id`  out  `SEQ_W`  head seq_id
- `o_wb_mask`  out  `MASK_W`  head byte enables
- `i_wb_rdy`  in  1  writeback accepts head
- `o_load_credit`  out  1  one-cycle pulse per returned credit
- `o_lq_empty`  out  1  no entries held
- `o_lq_count`  out  `$clog2(DEPTH)+1`  occupancy
- `o_overflow`  out  1  sticky: beat arrived while full with no pop

## Operation
- Circular buffer with write pointer `wr_ptr`, read pointer `rd_ptr` and occupancy `count`.
  - Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
  - `count` is one bit wider.
- Push when `i_load_valid`: write the entry at `wr_ptr` and increment `wr_ptr`.
- Pop when `o_wb_valid && i_wb_rdy`: increment `rd_ptr`.
- Push and pop in the same cycle leave `count` unchanged. This is legal at full and at empty+1.
- Push while `count==DEPTH` with no pop in the same cycle:
  - The beat is dropped.
  - Pointers and `count` are unchanged.
  - `o_overflow` sets and stays set until reset.
  - This is a credit-protocol violation and is flagged for assertion checking.
- Outputs are combinational from state:
  - `o_wb_valid = (count!=0)`.
  - `o_wb_*` = entry at `rd_ptr`.
  - `o_lq_empty = (count==0)`.
  - `o_lq_count = count`.
- Credit return: `o_load_credit` is registered and is high exactly one cycle after each pop cycle. The number of pulses always equals the number of pops.
- Entries are never reordered or modified; `seq_id` and mask pass through unchanged.
- Reset values:
  - `wr_ptr=rd_ptr=count=0`.
  - `o_wb_valid=0`, `o_lq_empty=1`, `o_load_credit=0`, `o_overflow=0`.
  - `o_wb_data/seq_id/mask` are don't-care while `o_wb_valid=0`; storage is not reset.
- Reset mid-operation: all held entries are discarded. Pending credit pulses are cancelled; the core re-initialises its credits to `DEPTH` on reset.

## Timing
- Push→visible: a beat pushed in cycle N (queue empty) gives `o_wb_valid=1` in N+1. There is no same-cycle bypass.
- Pop→credit: a pop in cycle N gives `o_load_credit=1` in N+1.
- Pop at `count==1` with no push: `o_lq_empty=1` in N+1.
- Pop at `count==1` with a simultaneous push: `o_lq_empty` stays 0 and the new beat is at head in N+1.
- Throughput: one push and one pop per cycle sustained.
- `i_wb_rdy` may be asserted while `o_wb_valid=0`; it has no effect.

## Structure
- Shared package `tt_vpu_pkg` holds:
  - `LQ_DEPTH`, `LQ_PTR_W`.
  - `OVI_SEQ_W`.
  - A packed `lq_entry_t` struct with fields data, mask and seq_id.
- Sub-module `tt_lq_storage` is a `DEPTH`×`lq_entry_t` register array.
  - One write port: enable, address, entry.
  - One asynchronous read port.
  - This allows a later swap to SRAM.
- Pointer, count, credit and overflow logic stay in the top module.

## Test plan
- Reset with `i_load_valid=0`: `o_lq_empty=1`, `o_lq_count=0`, `o_wb_valid=0`, `o_load_credit=0`, `o_overflow=0`.
- Push a single beat with seq_id=5, mask=64'hFF in cycle 1, `i_wb_rdy=0`:
  - `o_wb_valid=1`, `o_wb_seq_id=5` from cycle 2.
  - Assert `i_wb_rdy` in cycle 3: `o_load_credit=1` in cycle 4 only, and `o_lq_empty=1` in cycle 4.
- Push 16 beats (seq 0–15) back-to-back with `i_wb_rdy=0`:
  - `o_lq_count=16`.
  - A 17th push sets `o_overflow`, `count` stays 16, and the drain yields seq 0–15 in order with 16 credit pulses.
- Full queue, simultaneous push (seq 16) and pop:
  - `count` stays 16 and `o_overflow` stays 0.
  - Drain order is 1…16, exercising pointer wrap.
- Random `i_load_valid` and `i_wb_rdy` over 10k cycles, keeping outstanding pushes minus credits ≤16:
  - Output order matches input order.
  - Total pulses equal total pops.
  - `o_lq_empty` equals `(count==0)` every cycle.
- Reset asserted with `count=7`: the next cycle shows `o_lq_empty=1`, no credit pulses, and pushes resume at slot 0.
